// File: rtl/usb_tx_sequencer_if.sv
// ---------------------------------------------------------------------------
// usb_tx_sequencer_if : request and serial-bit handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface usb_tx_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic [3:0]  req_pid;
  logic [6:0]  req_addr;
  logic [3:0]  req_endp;
  logic [63:0] req_data;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        bit_last;
  logic        done;
  logic        err;
  logic        busy;

  modport master (
    output req_valid, req_type, req_pid, req_addr, req_endp, req_data, bit_ready,
    input  req_ready, bit_out, bit_valid, bit_last, done, err, busy
  );

  modport slave (
    input  req_valid, req_type, req_pid, req_addr, req_endp, req_data, bit_ready,
    output req_ready, bit_out, bit_valid, bit_last, done, err, busy
  );
endinterface

`default_nettype wire

// File: rtl/usb_tx_sequencer.sv
// ---------------------------------------------------------------------------
// usb_tx_sequencer : serial SYNC/PID/field/CRC packet emitter with stall handshake
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usb_tx_sequencer (
  input  wire logic          clk,
  input  wire logic          rst_b,
  usb_tx_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_PID   = 3'd2,
    S_FIELD = 3'd3,
    S_CRC   = 3'd4
  } state_t;

  localparam logic [1:0]  TYPE_TOKEN   = 2'b00;
  localparam logic [1:0]  TYPE_HSHAKE  = 2'b10;
  localparam logic [1:0]  TYPE_ILLEGAL = 2'b11;
  localparam logic [4:0]  CRC5_POLY    = 5'h05;
  localparam logic [15:0] CRC16_POLY   = 16'h8005;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [1:0]  type_q, type_d;
  logic [3:0]  pid_q, pid_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  endp_q, endp_d;
  logic [63:0] data_q, data_d;
  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        w_accept;
  logic        w_xfer;
  logic        w_is_tok;
  logic        w_is_hs;
  logic [6:0]  w_tc;
  logic        w_term;
  logic        w_bit;
  logic        w_last;
  logic [6:0]  w_endp_idx;
  logic [6:0]  w_crc5_idx;
  logic [6:0]  w_crc16_idx;

  assign w_accept    = bus.req_valid && bus.req_ready;
  assign w_xfer      = bus.bit_valid && bus.bit_ready;
  assign w_is_tok    = (type_q == TYPE_TOKEN);
  assign w_is_hs     = (type_q == TYPE_HSHAKE);
  assign w_endp_idx  = cnt_q - 7'd7;
  assign w_crc5_idx  = 7'd4 - cnt_q;
  assign w_crc16_idx = 7'd15 - cnt_q;

  // Terminal count of the current state; the counter never runs past it.
  always_comb begin
    w_tc = 7'd0;
    case (state_q)
      S_SYNC:  w_tc = 7'd8;
      S_PID:   w_tc = 7'd8;
      S_FIELD: w_tc = w_is_tok ? 7'd11 : 7'd64;
      S_CRC:   w_tc = w_is_tok ? 7'd5 : 7'd16;
      default: w_tc = 7'd0;
    endcase
  end

  assign w_term = w_xfer && (cnt_q == w_tc - 7'd1);

  // Output bit is a pure function of registered state, so it holds through stalls.
  always_comb begin
    w_bit  = 1'b0;
    w_last = 1'b0;
    case (state_q)
      S_SYNC: w_bit = (cnt_q == 7'd7);
      S_PID: begin
        w_bit  = cnt_q[2] ? ~pid_q[cnt_q[1:0]] : pid_q[cnt_q[1:0]];
        w_last = w_is_hs && (cnt_q == 7'd7);
      end
      S_FIELD: begin
        if (w_is_tok)
          w_bit = (cnt_q < 7'd7) ? addr_q[cnt_q[2:0]] : endp_q[w_endp_idx[1:0]];
        else
          w_bit = data_q[cnt_q[5:0]];
      end
      S_CRC: begin
        w_bit  = w_is_tok ? ~crc5_q[w_crc5_idx[2:0]] : ~crc16_q[w_crc16_idx[3:0]];
        w_last = (cnt_q == w_tc - 7'd1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    pid_d   = pid_q;
    addr_d  = addr_q;
    endp_d  = endp_q;
    data_d  = data_q;
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    err_d   = 1'b0;
    done_d  = w_xfer && w_last;
    if (w_xfer)
      cnt_d = cnt_q + 7'd1;

    case (state_q)
      S_IDLE: begin
        cnt_d = 7'd0;
        if (w_accept) begin
          if (bus.req_type == TYPE_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            state_d = S_SYNC;
            type_d  = bus.req_type;
            pid_d   = bus.req_pid;
            addr_d  = bus.req_addr;
            endp_d  = bus.req_endp;
            data_d  = bus.req_data;
          end
        end
      end
      S_SYNC: begin
        if (w_term) begin
          state_d = S_PID;
          cnt_d   = 7'd0;
        end
      end
      S_PID: begin
        if (w_term) begin
          cnt_d = 7'd0;
          if (w_is_hs) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FIELD;
            crc5_d  = '1;
            crc16_d = '1;
          end
        end
      end
      S_FIELD: begin
        if (w_xfer) begin
          if (w_is_tok)
            crc5_d = {crc5_q[3:0], 1'b0} ^ ((crc5_q[4] ^ w_bit) ? CRC5_POLY : 5'h00);
          else
            crc16_d = {crc16_q[14:0], 1'b0} ^ ((crc16_q[15] ^ w_bit) ? CRC16_POLY : 16'h0000);
        end
        if (w_term) begin
          state_d = S_CRC;
          cnt_d   = 7'd0;
        end
      end
      S_CRC: begin
        if (w_term) begin
          state_d = S_IDLE;
          cnt_d   = 7'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 7'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= 7'd0;
      type_q  <= 2'b00;
      pid_q   <= 4'h0;
      addr_q  <= 7'h00;
      endp_q  <= 4'h0;
      data_q  <= 64'h0;
      crc5_q  <= '1;
      crc16_q <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      pid_q   <= pid_d;
      addr_q  <= addr_d;
      endp_q  <= endp_d;
      data_q  <= data_d;
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.bit_valid = (state_q != S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.bit_out   = w_bit;
  assign bus.bit_last  = w_last;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

`default_nettype wire
